fb_rect_reader: RTL and testbench
=================================

Name: fb_rect_reader

Overview:
- Read-side counterpart of the digit/pixel renderers: fetches a rectangular region from the 640x480 RGB565 framebuffer and streams it out as pixels.
- Intended consumers: sprite save/restore, region copy, and the screenshot/UART dump path.
- Issues framebuffer read addresses, absorbs fixed memory read latency in a small FIFO, and delivers pixels in raster order over a valid/ready stream.

Parameters:
- SCREEN_W, 640, framebuffer width in pixels.
- SCREEN_H, 480, framebuffer height in pixels.
- RD_LAT, 1, framebuffer read latency in cycles from src_rd to src_data valid (1..3).
- FIFO_DEPTH, 4, output buffer entries; must be at least RD_LAT+1, power of two.
- CLIP_COLOR, 16'h0000, data emitted for pixels outside the screen.

Ports:
- clk  in  1  system clock, 100MHz.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept a request.
- req_top  in  10  rectangle top row.
- req_left  in  10  rectangle left column.
- req_width  in  10  columns, 0..1023.
- req_height  in  10  rows, 0..1023.
- src_addr  out  19  framebuffer read address, y*SCREEN_W+x.
- src_rd  out  1  read strobe, one read per cycle when high.
- src_data  in  16  read data, valid exactly RD_LAT cycles after src_rd.
- out_valid  out  1  pixel available.
- out_ready  in  1  consumer accepts pixel.
- out_data  out  16  RGB565 pixel.
- out_last  out  1  marks final pixel of the rectangle.
- done  out  1  one-cycle pulse when the final pixel is accepted, or when a zero-size request is accepted.

Behaviour:
- Reset: state IDLE; req_ready=1, src_rd=0, src_addr=0, out_valid=0, out_last=0, done=0; FIFO and in-flight counters cleared. Reset mid-transfer aborts immediately; in-flight returning data is discarded and nothing is emitted.
- Request accept: occurs when req_valid && req_ready. All req_* fields are latched; req_ready stays 0 until return to IDLE.
- Zero size: width==0 or height==0 → no reads, no pixels; done=1 the cycle after accept; back to IDLE.
- States:
  - IDLE: waiting for a request.
  - ISSUE: walking the rectangle with column counter cx 0..width-1 and row counter cy 0..height-1, raster order. Moves to DRAIN after the last position is issued.
  - DRAIN: waiting for FIFO empty and in-flight==0 with the final pixel accepted. Then done=1 for one cycle and return to IDLE, with req_ready=1 in that same cycle.
- Issue rule:
  - One position is issued per cycle in ISSUE only when fifo_count + inflight < FIFO_DEPTH. This guarantees no overflow, and no src_data is ever dropped under backpressure.
  - x=left+cx, y=top+cy, computed at 11 bits, with no wrap-around.
  - If x<SCREEN_W and y<SCREEN_H: src_rd=1, src_addr=y*SCREEN_W+x.
  - Otherwise: src_rd=0, and a clip token travels the same RD_LAT delay line, so ordering is preserved and CLIP_COLOR is written into the FIFO.
- Latency:
  - Accept at edge 0; first src_rd high in cycle 1.
  - Data enters the FIFO at cycle 1+RD_LAT; out_valid first high in cycle RD_LAT+2.
  - With out_ready held high, throughput is 1 pixel/cycle.
- Stream rules:
  - out_data and out_last hold stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
  - out_last=1 only on pixel index width*height-1.
- Simultaneous FIFO push and pop when full is legal; count is unchanged.
- Total pixel count is width*height, up to 20 bits; counters must not overflow at 1023x1023.

Test Plan:
- Reset, then request top=2, left=3, w=2, h=2, RD_LAT=1, out_ready=1 → src_addr sequence 1283,1284,1923,1924 on cycles 1-4; out_valid from cycle 3; out_last on 4th pixel; done pulse on the cycle after the last transfer.
- Same request with out_ready toggling 1,0,0,1,... and RD_LAT=3 → all 4 pixels in order with correct data; src_rd throttles so fifo_count+inflight never exceeds 4; no data loss.
- Request left=638, top=479, w=4, h=2 → pixels (638,479),(639,479) read at addresses 307198,307199; the remaining 6 pixels emit CLIP_COLOR with no src_rd; total 8 pixels in order.
- Request w=0, h=5 → no src_rd, no out_valid; done pulse 1 cycle after accept; req_ready=1 again.
- Assert rst mid-transfer after 3 of 16 pixels of a 4x4 request → next cycle out_valid=0, src_rd=0, req_ready=1; a new 1x1 request then completes normally with a single out_last pixel.
- req_valid held high during an active transfer → not accepted until after done; the second request starts exactly on the req_ready=1 cycle.

Source files
------------

// File: rtl/fb_rect_reader_if.sv
// Request, framebuffer-read and pixel-stream signals of fb_rect_reader.
// master = the reader block itself, slave = the logic around it.
interface fb_rect_reader_if;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_top;
  logic [9:0]  req_left;
  logic [9:0]  req_width;
  logic [9:0]  req_height;
  logic [18:0] src_addr;
  logic        src_rd;
  logic [15:0] src_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;
  logic        done;

  modport master (
    input  req_valid, req_top, req_left, req_width, req_height, src_data, out_ready,
    output req_ready, src_addr, src_rd, out_valid, out_data, out_last, done
  );

  modport slave (
    output req_valid, req_top, req_left, req_width, req_height, src_data, out_ready,
    input  req_ready, src_addr, src_rd, out_valid, out_data, out_last, done
  );
endinterface

// File: rtl/fb_rect_reader.sv
// Streams a framebuffer rectangle in raster order, off-screen pixels replaced by CLIP_COLOR.
// First pixel RD_LAT+2 cycles after accept; reads throttle on FIFO room so out_ready stalls never lose data.

module fb_rect_fifo #(
  parameter int W     = 17,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = DEPTH[CW-1:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          wr_en, rd_en;

  assign rd_en   = pop && (count != '0);
  // Push into a full FIFO is fine when the head leaves in the same cycle.
  assign wr_en   = push && ((count != FULL) || rd_en);
  assign pop_dat = mem[rd_ptr];
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

module fb_rect_reader #(
  parameter int          SCREEN_W   = 640,
  parameter int          SCREEN_H   = 480,
  parameter int          RD_LAT     = 1,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] CLIP_COLOR = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  fb_rect_reader_if.master  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [10:0] SW      = 11'(SCREEN_W);
  localparam logic [10:0] SH      = 11'(SCREEN_H);
  localparam logic [CW:0] DEPTH_L = FIFO_DEPTH[CW:0];

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  typedef struct packed {
    logic vld;
    logic clip;
    logic last;
  } tok_t;

  state_t        state_q, state_d;
  logic [9:0]    top_q, left_q, w_q, h_q, cx_q, cy_q;
  logic          done_q;
  logic          accept, zero_req, room, issue_en, in_screen, last_pos, pop;
  logic [10:0]   x_pos, y_pos;
  tok_t          tok_in;
  tok_t          tok_q [RD_LAT];
  logic [CW:0]   inflight;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [16:0]   fifo_head;

  assign accept    = bus.req_valid && (state_q == IDLE);
  assign zero_req  = (bus.req_width == 10'd0) || (bus.req_height == 10'd0);
  assign x_pos     = {1'b0, left_q} + {1'b0, cx_q};
  assign y_pos     = {1'b0, top_q} + {1'b0, cy_q};
  assign in_screen = (x_pos < SW) && (y_pos < SH);
  assign last_pos  = (cx_q == w_q - 10'd1) && (cy_q == h_q - 10'd1);
  // Reserve a FIFO slot for every read still in the latency pipe.
  assign room      = ({1'b0, fifo_count} + inflight) < DEPTH_L;
  assign pop       = !fifo_empty && bus.out_ready;
  assign tok_in    = '{vld: issue_en, clip: !in_screen, last: last_pos};

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + {{CW{1'b0}}, tok_q[i].vld};
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !zero_req) state_d = ISSUE;
      ISSUE:   if (issue_en && last_pos) state_d = DRAIN;
      DRAIN:   if (pop && fifo_head[16]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = (state_q == IDLE);
    issue_en      = (state_q == ISSUE) && room;
    bus.src_rd    = issue_en && in_screen;
    bus.src_addr  = '0;
    if (bus.src_rd) bus.src_addr = 19'(y_pos) * 19'(SCREEN_W) + 19'(x_pos);
    bus.done      = done_q;
    bus.out_valid = !fifo_empty;
    bus.out_data  = fifo_head[15:0];
    bus.out_last  = fifo_head[16] && !fifo_empty;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top_q  <= '0;
      left_q <= '0;
      w_q    <= '0;
      h_q    <= '0;
      cx_q   <= '0;
      cy_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (accept && zero_req) || ((state_q == DRAIN) && pop && fifo_head[16]);
      if (accept) begin
        top_q  <= bus.req_top;
        left_q <= bus.req_left;
        w_q    <= bus.req_width;
        h_q    <= bus.req_height;
        cx_q   <= '0;
        cy_q   <= '0;
      end else if (issue_en) begin
        if (cx_q == w_q - 10'd1) begin
          cx_q <= '0;
          cy_q <= cy_q + 10'd1;
        end else begin
          cx_q <= cx_q + 10'd1;
        end
      end
    end
  end

  // Clip tokens ride the same delay as real reads so FIFO order matches raster order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tok_q[i] <= '0;
    end else begin
      for (int i = RD_LAT - 1; i > 0; i--) tok_q[i] <= tok_q[i-1];
      tok_q[0] <= tok_in;
    end
  end

  fb_rect_fifo #(.W(17), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (tok_q[RD_LAT-1].vld),
    .push_dat ({tok_q[RD_LAT-1].last, tok_q[RD_LAT-1].clip ? CLIP_COLOR : bus.src_data}),
    .pop      (pop),
    .pop_dat  (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );
endmodule

// File: tb/tb_fb_rect_reader.sv
// Scoreboard bench: instance a (RD_LAT=1) for exact cycle timing, instance b (RD_LAT=3) under backpressure.
module tb_fb_rect_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fb_rect_reader_if bus_a ();
  fb_rect_reader_if bus_b ();

  fb_rect_reader #(.RD_LAT(1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  fb_rect_reader #(.RD_LAT(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] exp_pix_a [$];
  logic [16:0] exp_pix_b [$];
  logic [18:0] exp_adr_a [$];
  logic [18:0] exp_adr_b [$];
  int rd_cnt_a = 0, rd_cnt_b = 0, pix_cnt_a = 0, pix_cnt_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pix(input logic [18:0] a);
    return a[15:0] ^ 16'hA5A5 ^ {a[18:16], 13'd0};
  endfunction

  // Framebuffer models: data appears exactly RD_LAT cycles after src_rd.
  logic        ma_v = 1'b0;
  logic [18:0] ma_ad = '0;
  logic [2:0]  mb_v = '0;
  logic [18:0] mb_ad [3];
  always @(posedge clk) begin
    ma_v     <= bus_a.src_rd;
    ma_ad    <= bus_a.src_addr;
    mb_v     <= {mb_v[1:0], bus_b.src_rd};
    mb_ad[2] <= mb_ad[1];
    mb_ad[1] <= mb_ad[0];
    mb_ad[0] <= bus_b.src_addr;
  end
  assign bus_a.src_data = ma_v ? pix(ma_ad) : 16'hDEAD;
  assign bus_b.src_data = mb_v[2] ? pix(mb_ad[2]) : 16'hDEAD;

  logic        stall_a = 1'b0, stall_b = 1'b0;
  logic [16:0] held_a, held_b, e_a, e_b;

  always @(negedge clk) begin
    if (rst) stall_a = 1'b0;
    else begin
      if (stall_a) begin
        check("a_hold_valid", bus_a.out_valid, 1);
        check("a_hold_data", {bus_a.out_last, bus_a.out_data}, held_a);
      end
      if (bus_a.src_rd) begin
        rd_cnt_a++;
        check("a_rd_expected", exp_adr_a.size() > 0, 1);
        if (exp_adr_a.size() > 0) check("a_rd_addr", bus_a.src_addr, exp_adr_a.pop_front());
      end
      if (bus_a.out_valid && bus_a.out_ready) begin
        pix_cnt_a++;
        check("a_pix_expected", exp_pix_a.size() > 0, 1);
        if (exp_pix_a.size() > 0) begin
          e_a = exp_pix_a.pop_front();
          check("a_pix_data", bus_a.out_data, e_a[15:0]);
          check("a_pix_last", bus_a.out_last, e_a[16]);
        end
      end
      stall_a = bus_a.out_valid && !bus_a.out_ready;
      held_a  = {bus_a.out_last, bus_a.out_data};
    end
  end

  always @(negedge clk) begin
    if (rst) stall_b = 1'b0;
    else begin
      if (stall_b) begin
        check("b_hold_valid", bus_b.out_valid, 1);
        check("b_hold_data", {bus_b.out_last, bus_b.out_data}, held_b);
      end
      if (bus_b.src_rd) begin
        rd_cnt_b++;
        check("b_occupancy_le_4", (rd_cnt_b - pix_cnt_b) <= 4, 1);
        check("b_rd_expected", exp_adr_b.size() > 0, 1);
        if (exp_adr_b.size() > 0) check("b_rd_addr", bus_b.src_addr, exp_adr_b.pop_front());
      end
      if (bus_b.out_valid && bus_b.out_ready) begin
        pix_cnt_b++;
        check("b_pix_expected", exp_pix_b.size() > 0, 1);
        if (exp_pix_b.size() > 0) begin
          e_b = exp_pix_b.pop_front();
          check("b_pix_data", bus_b.out_data, e_b[15:0]);
          check("b_pix_last", bus_b.out_last, e_b[16]);
        end
      end
      stall_b = bus_b.out_valid && !bus_b.out_ready;
      held_b  = {bus_b.out_last, bus_b.out_data};
    end
  end

  task automatic drive_fields(input int sel, input bit v, input int top, input int left, input int w, input int h);
    if (sel == 0) begin
      bus_a.req_valid = v; bus_a.req_top = 10'(top); bus_a.req_left = 10'(left);
      bus_a.req_width = 10'(w); bus_a.req_height = 10'(h);
    end else begin
      bus_b.req_valid = v; bus_b.req_top = 10'(top); bus_b.req_left = 10'(left);
      bus_b.req_width = 10'(w); bus_b.req_height = 10'(h);
    end
  endtask

  task automatic push_exp(input int sel, input int top, input int left, input int w, input int h);
    for (int cy = 0; cy < h; cy++) begin
      for (int cx = 0; cx < w; cx++) begin
        int x, y;
        logic in_scr;
        logic [18:0] ad;
        logic [16:0] e;
        x = left + cx;
        y = top + cy;
        in_scr = (x < 640) && (y < 480);
        ad = 19'(y * 640 + x);
        e = {(cy == h - 1) && (cx == w - 1), in_scr ? pix(ad) : 16'h0000};
        if (sel == 0) begin
          exp_pix_a.push_back(e);
          if (in_scr) exp_adr_a.push_back(ad);
        end else begin
          exp_pix_b.push_back(e);
          if (in_scr) exp_adr_b.push_back(ad);
        end
      end
    end
  endtask

  // Returns at posedge+1 of the first cycle after the accepting edge.
  task automatic send_req(input int sel, input int top, input int left, input int w, input int h);
    logic rdy;
    rdy = 1'b0;
    @(posedge clk); #1;
    drive_fields(sel, 1'b1, top, left, w, h);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      rdy = (sel == 0) ? bus_a.req_ready : bus_b.req_ready;
      if (rdy) break;
    end
    if (!rdy) check("req_accept_timeout", rdy, 1);
    @(posedge clk); #1;
    push_exp(sel, top, left, w, h);
    drive_fields(sel, 1'b0, top, left, w, h);
  endtask

  // mode 0: out_ready high, 1: pattern 1,0,0,1, 2: random.
  task automatic wait_done(input int sel, input int mode, input int budget);
    logic d, r;
    d = 1'b0;
    for (int i = 0; i < budget; i++) begin
      r = (mode == 0) ? 1'b1 : (mode == 1) ? ((i % 4 == 0) || (i % 4 == 3)) : 1'($urandom_range(0, 1));
      if (sel == 0) bus_a.out_ready = r; else bus_b.out_ready = r;
      @(negedge clk);
      d = (sel == 0) ? bus_a.done : bus_b.done;
      if (d) break;
      @(posedge clk); #1;
    end
    if (!d) check("done_timeout", d, 1);
    if (sel == 0) bus_a.out_ready = 1'b1; else bus_b.out_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] rd_v, vld_v, last_v, done_v, rdy_v;
    int base_rd, base_pix, busy;

    rst = 1'b1;
    bus_a.out_ready = 1'b1;
    bus_b.out_ready = 1'b1;
    drive_fields(0, 1'b0, 0, 0, 0, 0);
    drive_fields(1, 1'b0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus_a.req_ready, 1);
    check("rst_src_rd", bus_a.src_rd, 0);
    check("rst_src_addr", bus_a.src_addr, 0);
    check("rst_out_valid", {bus_a.out_valid, bus_b.out_valid}, 0);
    check("rst_out_last", bus_a.out_last, 0);
    check("rst_done", {bus_a.done, bus_b.done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Exact timing, RD_LAT=1: bit k of each vector is cycle k+1 after accept.
    send_req(0, 2, 3, 2, 2);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rd_v[c] = bus_a.src_rd; vld_v[c] = bus_a.out_valid; last_v[c] = bus_a.out_last;
      done_v[c] = bus_a.done; rdy_v[c] = bus_a.req_ready;
    end
    check("t1_src_rd_cycles", rd_v, 8'h0F);
    check("t1_out_valid_cycles", vld_v, 8'h3C);
    check("t1_out_last_cycles", last_v, 8'h20);
    check("t1_done_cycles", done_v, 8'h40);
    check("t1_req_ready_cycles", rdy_v, 8'hC0);

    // Zero-size request.
    base_rd = rd_cnt_a;
    send_req(0, 0, 0, 0, 5);
    @(negedge clk);
    check("zero_done", bus_a.done, 1);
    check("zero_req_ready", bus_a.req_ready, 1);
    check("zero_out_valid", bus_a.out_valid, 0);
    @(negedge clk);
    check("zero_done_one_cycle", bus_a.done, 0);
    check("zero_no_reads", rd_cnt_a - base_rd, 0);

    // Bottom-right corner clipping.
    base_rd = rd_cnt_a; base_pix = pix_cnt_a;
    send_req(0, 479, 638, 4, 2);
    wait_done(0, 0, 100);
    check("clip_a_reads", rd_cnt_a - base_rd, 2);
    check("clip_a_pixels", pix_cnt_a - base_pix, 8);

    // Request held during a transfer is taken on the done/req_ready cycle.
    send_req(0, 2, 3, 2, 2);
    drive_fields(0, 1'b1, 10, 20, 3, 1);
    busy = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus_a.req_ready) break;
      busy++;
    end
    check("held_busy_cycles", busy, 6);
    check("held_done_with_ready", bus_a.done, 1);
    @(posedge clk); #1;
    push_exp(0, 10, 20, 3, 1);
    drive_fields(0, 1'b0, 10, 20, 3, 1);
    @(negedge clk);
    check("held_second_starts", bus_a.src_rd, 1);
    wait_done(0, 0, 100);

    // Reset after 3 of 16 pixels.
    base_pix = pix_cnt_a;
    send_req(0, 100, 100, 4, 4);
    for (int i = 0; i < 100; i++) begin
      if (pix_cnt_a - base_pix >= 3) break;
      @(posedge clk); #1;
    end
    check("mid_rst_pixels_before", pix_cnt_a - base_pix, 3);
    rst = 1'b1;
    bus_a.out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_out_valid", bus_a.out_valid, 0);
    check("mid_rst_src_rd", bus_a.src_rd, 0);
    check("mid_rst_req_ready", bus_a.req_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    bus_a.out_ready = 1'b1;
    exp_pix_a.delete();
    exp_adr_a.delete();
    base_pix = pix_cnt_a;
    repeat (8) @(negedge clk);
    check("mid_rst_no_stale_pixels", pix_cnt_a - base_pix, 0);
    send_req(0, 5, 5, 1, 1);
    wait_done(0, 0, 100);
    check("post_rst_single_pixel", pix_cnt_a - base_pix, 1);

    // RD_LAT=3 with out_ready pattern 1,0,0,1.
    base_pix = pix_cnt_b;
    send_req(1, 2, 3, 2, 2);
    wait_done(1, 1, 200);
    check("b_toggle_pixels", pix_cnt_b - base_pix, 4);

    base_pix = pix_cnt_b;
    send_req(1, 60, 50, 8, 3);
    wait_done(1, 2, 500);
    check("b_random_pixels", pix_cnt_b - base_pix, 24);

    base_rd = rd_cnt_b; base_pix = pix_cnt_b;
    send_req(1, 479, 638, 4, 2);
    wait_done(1, 2, 300);
    check("clip_b_reads", rd_cnt_b - base_rd, 2);
    check("clip_b_pixels", pix_cnt_b - base_pix, 8);

    repeat (4) @(negedge clk);
    check("a_queue_drained", exp_pix_a.size() + exp_adr_a.size(), 0);
    check("b_queue_drained", exp_pix_b.size() + exp_adr_b.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
